// File: rtl/note_scheduler.sv
// note_scheduler
//   Plays a song chart stored in a synchronous ROM into the strum lanes.
//   Each chart entry is {mask, gap}: the mask is emitted on drop_block for one
//   frame interval, and gap frame ticks later the next entry is emitted.
//   An all-zero entry ends the song.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   frame_tick      one-cycle pulse per display frame (>= 4 clk apart)
//   start           one-cycle pulse, starts playback at chart address 0
//   pause           level; paused ticks do not advance the chart
//   rom_addr        chart ROM address
//   rom_data        chart ROM word, valid one cycle after rom_addr
//   drop_block      per-lane drop request, held for one frame interval
//   playing, done   playback status
//   note_count      lane-notes emitted since start, saturating
module note_scheduler #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 8,
  parameter int WAIT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    pause,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [LANES+WAIT_W-1:0] rom_data,
  output logic [LANES-1:0]        drop_block,
  output logic                    playing,
  output logic                    done,
  output logic [15:0]             note_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ARMED,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [WAIT_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [LANES-1:0]    pend_mask_reg, pend_mask_next;
  logic [WAIT_W-1:0]   pend_gap_reg, pend_gap_next;
  logic [LANES-1:0]    drop_reg, drop_next;
  logic [15:0]         count_reg, count_next;
  logic                playing_reg, playing_next;
  logic                done_reg, done_next;

  logic [LANES-1:0]    rom_mask;
  logic [WAIT_W-1:0]   rom_gap;
  logic [15:0]         pend_pop;
  logic [16:0]         count_sum;
  logic [15:0]         count_sat;
  logic                tick_live;

  assign rom_mask  = rom_data[LANES+WAIT_W-1:WAIT_W];
  assign rom_gap   = rom_data[WAIT_W-1:0];
  assign tick_live = frame_tick && !pause;

  // Number of lanes in the pending mask, added to note_count on emission.
  always_comb begin
    pend_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pend_pop = pend_pop + 16'(pend_mask_reg[i]);
    end
  end

  assign count_sum = {1'b0, count_reg} + {1'b0, pend_pop};
  assign count_sat = count_sum[16] ? 16'hFFFF : count_sum[15:0];

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    gap_cnt_next   = gap_cnt_reg;
    pend_mask_next = pend_mask_reg;
    pend_gap_next  = pend_gap_reg;
    drop_next      = drop_reg;
    count_next     = count_reg;

    // Any tick that does not emit clears the drop, so a drop lasts exactly
    // one frame interval regardless of state or pause.
    if (frame_tick) begin
      drop_next = '0;
    end

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_next    = '0;
          gap_cnt_next = WAIT_W'(1);
          count_next   = '0;
          state_next   = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (rom_data == '0) begin
          state_next = S_DONE;
        end else begin
          pend_mask_next = rom_mask;
          pend_gap_next  = rom_gap;
          state_next     = S_ARMED;
        end
      end
      S_ARMED: begin
        if (tick_live) begin
          if (gap_cnt_reg <= WAIT_W'(1)) begin
            drop_next    = pend_mask_reg;
            count_next   = count_sat;
            gap_cnt_next = (pend_gap_reg == '0) ? WAIT_W'(1) : pend_gap_reg;
            // The last ROM address ends the song rather than wrapping to 0.
            if (addr_reg == '1) begin
              state_next = S_DONE;
            end else begin
              addr_next  = addr_reg + ADDR_W'(1);
              state_next = S_FETCH;
            end
          end else begin
            gap_cnt_next = gap_cnt_reg - WAIT_W'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    playing_next = (state_next == S_FETCH) || (state_next == S_DECODE) ||
                   (state_next == S_ARMED);
    done_next    = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      gap_cnt_reg   <= WAIT_W'(1);
      pend_mask_reg <= '0;
      pend_gap_reg  <= '0;
      drop_reg      <= '0;
      count_reg     <= '0;
      playing_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      gap_cnt_reg   <= gap_cnt_next;
      pend_mask_reg <= pend_mask_next;
      pend_gap_reg  <= pend_gap_next;
      drop_reg      <= drop_next;
      count_reg     <= count_next;
      playing_reg   <= playing_next;
      done_reg      <= done_next;
    end
  end

  assign rom_addr   = addr_reg;
  assign drop_block = drop_reg;
  assign playing    = playing_reg;
  assign done       = done_reg;
  assign note_count = count_reg;

endmodule

// File: tb/tb_note_scheduler.sv
module tb_note_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 4 lanes, 8-bit address, 12-bit gap.
  logic        rst, frame_tick, start, pause;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  drop_block;
  logic        playing, done;
  logic [15:0] note_count;

  // Wide instance: 256 lanes, used for address end and count saturation.
  logic         start2, tick2, pause2;
  logic [7:0]   rom_addr2;
  logic [259:0] rom_data2;
  logic [255:0] drop2;
  logic         playing2, done2;
  logic [15:0]  note_count2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom_a [256];

  note_scheduler #(.LANES(4), .ADDR_W(8), .WAIT_W(12)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
    .rom_addr(rom_addr), .rom_data(rom_data), .drop_block(drop_block),
    .playing(playing), .done(done), .note_count(note_count)
  );

  note_scheduler #(.LANES(256), .ADDR_W(8), .WAIT_W(4)) dut2 (
    .clk(clk), .rst(rst), .frame_tick(tick2), .start(start2), .pause(pause2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .drop_block(drop2),
    .playing(playing2), .done(done2), .note_count(note_count2)
  );

  always @(posedge clk) rom_data <= rom_a[rom_addr];
  // Every entry of the wide chart is "all lanes, gap 1"; no marker anywhere.
  always @(posedge clk) rom_data2 <= {{256{1'b1}}, 4'd1};

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom_a[a] = 16'h0000;
  endtask

  // Plays the chart in rom_a and compares against an emission schedule:
  // entry k emits on unpaused tick number t_k, with t_0 = 1 and
  // t_{k+1} = t_k + max(gap_k, 1).
  task automatic play(input string name, input int nticks, input int pause_pct,
                      input logic [63:0] pause_vec, input int ign_tick,
                      input bit tick_with_start);
    int          tsched[$];
    logic [3:0]  masks[$];
    int          n, t, u, k, cnt;
    logic [3:0]  exp_drop;
    bit          pz;
    t = 1;
    for (int a = 0; a < 256; a++) begin
      logic [15:0] w;
      w = rom_a[a];
      if (w == 16'h0000) break;
      masks.push_back(w[15:12]);
      tsched.push_back(t);
      t += (w[11:0] == 12'd0) ? 1 : int'(w[11:0]);
    end
    n = masks.size();

    @(negedge clk);
    start = 1'b1;
    frame_tick = tick_with_start;
    @(negedge clk);
    start = 1'b0;
    frame_tick = 1'b0;
    n_checks++;
    if (note_count !== 16'd0) begin
      n_fail++;
      $display("FAIL %s start_clears_count: got %0d want 0", name, note_count);
    end
    if (tick_with_start) begin
      n_checks++;
      if (drop_block !== 4'b0000) begin
        n_fail++;
        $display("FAIL %s start_tick_drop: got %b want 0000", name, drop_block);
      end
    end
    repeat ($urandom_range(4, 2)) @(negedge clk);

    u = 0; k = 0; cnt = 0;
    for (int i = 0; i < nticks; i++) begin
      n_checks++;
      if (done !== (k == n) || playing !== (k != n)) begin
        n_fail++;
        $display("FAIL %s status tick%0d: got done=%b playing=%b want done=%b playing=%b",
                 name, i, done, playing, (k == n), (k != n));
      end
      pz = ((i < 64) && pause_vec[i]) || ($urandom_range(99) < pause_pct);
      frame_tick = 1'b1;
      pause = pz;
      @(negedge clk);
      frame_tick = 1'b0;
      pause = 1'b0;
      exp_drop = 4'b0000;
      if (!pz) begin
        u++;
        if (k < n && u == tsched[k]) begin
          exp_drop = masks[k];
          cnt = sat16(cnt + $countones(masks[k]));
          k++;
        end
      end
      $display("%s tick %0d pause=%0d drop=%b count=%0d", name, i, pz, drop_block, note_count);
      n_checks++;
      if (drop_block !== exp_drop) begin
        n_fail++;
        $display("FAIL %s drop tick%0d: got %b want %b", name, i, drop_block, exp_drop);
      end
      n_checks++;
      if (note_count !== 16'(cnt)) begin
        n_fail++;
        $display("FAIL %s count tick%0d: got %0d want %0d", name, i, note_count, cnt);
      end
      if (i == ign_tick && k < n) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      repeat ($urandom_range(7, 3)) @(negedge clk);
    end
    n_checks++;
    if (done !== (k == n)) begin
      n_fail++;
      $display("FAIL %s final_done: got %b want %b", name, done, (k == n));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rom_addr !== 8'd0 || drop_block !== 4'd0 || playing !== 1'b0 ||
        done !== 1'b0 || note_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%0d drop=%b playing=%b done=%b count=%0d want all 0",
               rom_addr, drop_block, playing, done, note_count);
    end
    n_checks++;
    if (rom_addr2 !== 8'd0 || drop2 !== '0 || playing2 !== 1'b0 ||
        done2 !== 1'b0 || note_count2 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values_wide: got addr=%0d playing=%b done=%b count=%0d want all 0",
               rom_addr2, playing2, done2, note_count2);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_basic();
    clear_rom();
    rom_a[0] = {4'b0001, 12'd3};
    rom_a[1] = {4'b0100, 12'd2};
    play("basic", 7, 0, 64'd0, -1, 1'b0);
  endtask

  task automatic test_chord_gap0();
    clear_rom();
    rom_a[0] = {4'b1111, 12'd0};
    rom_a[1] = {4'b0010, 12'd1};
    play("chord", 5, 0, 64'd0, -1, 1'b0);
  endtask

  task automatic test_pause_rest();
    clear_rom();
    rom_a[0] = {4'b0001, 12'd2};
    rom_a[1] = {4'b0000, 12'd1};
    rom_a[2] = {4'b1000, 12'd1};
    play("pause_rest", 8, 0, 64'b10, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom_a[0] = {4'b0010, 12'd4};
    rom_a[1] = {4'b0001, 12'd1};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_checks++;
    if (drop_block !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_mid_drop: got %b want 0010", drop_block);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    $display("reset_mid after rst addr=%0d drop=%b count=%0d", rom_addr, drop_block, note_count);
    n_checks++;
    if (rom_addr !== 8'd0 || drop_block !== 4'd0 || playing !== 1'b0 ||
        done !== 1'b0 || note_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_values: got addr=%0d drop=%b playing=%b done=%b count=%0d want all 0",
               rom_addr, drop_block, playing, done, note_count);
    end
    play("replay", 8, 0, 64'd0, -1, 1'b0);
  endtask

  task automatic test_ignored_start();
    clear_rom();
    rom_a[0] = {4'b0101, 12'd2};
    rom_a[1] = {4'b1010, 12'd1};
    rom_a[2] = {4'b0011, 12'd1};
    play("ign_start", 7, 0, 64'd0, 0, 1'b0);
    play("restart", 7, 0, 64'd0, -1, 1'b0);
  endtask

  task automatic test_start_with_tick();
    clear_rom();
    rom_a[0] = {4'b1001, 12'd1};
    rom_a[1] = {4'b0110, 12'd2};
    play("start_tick", 6, 0, 64'd0, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int len, sum;
      clear_rom();
      len = $urandom_range(10, 3);
      sum = 0;
      for (int a = 0; a < len; a++) begin
        logic [3:0]  m;
        logic [11:0] g;
        m = 4'($urandom_range(15, 0));
        g = 12'($urandom_range(3, 0));
        if (m == 4'd0 && g == 12'd0) g = 12'd2;
        rom_a[a] = {m, g};
        sum += (g == 12'd0) ? 1 : int'(g);
      end
      play($sformatf("rand%0d", r), 2 * sum + 8, 25, 64'd0, -1, 1'b0);
    end
  endtask

  task automatic test_addr_end_sat();
    int k, cnt;
    logic [255:0] exp2;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    k = 0; cnt = 0;
    for (int i = 0; i < 260; i++) begin
      n_checks++;
      if (done2 !== (k == 256) || playing2 !== (k != 256)) begin
        n_fail++;
        $display("FAIL wide status tick%0d: got done=%b playing=%b want done=%b",
                 i, done2, playing2, (k == 256));
      end
      tick2 = 1'b1;
      @(negedge clk);
      tick2 = 1'b0;
      exp2 = '0;
      if (k < 256) begin
        exp2 = '1;
        cnt = sat16(cnt + 256);
        k++;
      end
      n_checks++;
      if (drop2 !== exp2) begin
        n_fail++;
        $display("FAIL wide drop tick%0d: got ones=%0d want ones=%0d",
                 i, $countones(drop2), $countones(exp2));
      end
      n_checks++;
      if (note_count2 !== 16'(cnt)) begin
        n_fail++;
        $display("FAIL wide count tick%0d: got %0d want %0d", i, note_count2, cnt);
      end
      if (i >= 250) $display("wide tick %0d addr=%0d count=%0d done=%b", i, rom_addr2, note_count2, done2);
      repeat (3) @(negedge clk);
    end
    n_checks++;
    if (rom_addr2 !== 8'hFF || done2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wide addr_end: got addr=%0d done=%b want addr=255 done=1", rom_addr2, done2);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0;
    start2 = 1'b0; tick2 = 1'b0; pause2 = 1'b0;
    clear_rom();
    test_reset();
    test_basic();
    test_chord_gap0();
    test_pause_rest();
    test_reset_mid();
    test_ignored_start();
    test_start_with_tick();
    test_random();
    test_addr_end_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
